gemm_launch_ctrl: RTL and testbench

Sequencer between the CSR manager and the GEMM core's control port. It buffers one pending GEMM configuration (K, N, M, subtraction constant) and issues it to the core with a valid/ready handshake. It then tracks output-tile handshakes until the job completes, and reports busy, done, cycle count, output count and error status. One job may be queued while another runs, so software can double-buffer launches.

---
 rtl/gemm_launch_ctrl.sv | 148 ++++++++++++++
 tb/tb_gemm_launch_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_launch_ctrl.sv
// GEMM launch sequencer: one-deep config buffer, ctrl handshake to the core,
// output-tile tracking, and busy/done/perf/error status for the CSR block.
module gemm_launch_ctrl #(
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned DimWidth     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [3:0][RegDataWidth-1:0] csr_cfg_i,
    input  logic                         csr_cfg_valid_i,
    output logic                         csr_cfg_ready_o,
    input  logic                         err_clr_i,
    output logic                         gemm_ctrl_valid_o,
    input  logic                         gemm_ctrl_ready_i,
    output logic [RegDataWidth-1:0]      gemm_k_o,
    output logic [RegDataWidth-1:0]      gemm_n_o,
    output logic [RegDataWidth-1:0]      gemm_m_o,
    output logic [RegDataWidth-1:0]      gemm_sub_o,
    input  logic                         gemm_c_valid_i,
    input  logic                         gemm_c_ready_i,
    input  logic                         gemm_busy_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [RegDataWidth-1:0]      perf_cycles_o,
    output logic [RegDataWidth-1:0]      out_count_o,
    output logic [1:0]                   err_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN
    } state_e;

    state_e                         state_q, state_d;
    logic                           pend_valid_q, pend_valid_d;
    logic [3:0][RegDataWidth-1:0]   pend_cfg_q, pend_cfg_d;
    logic [RegDataWidth-1:0]        expected_q, expected_d;
    logic [RegDataWidth-1:0]        out_count_q, out_count_d;
    logic [RegDataWidth-1:0]        perf_q, perf_d;
    logic                           done_q, done_d;
    logic [1:0]                     err_q, err_d;
    logic                           cfg_ready_q, cfg_ready_d;

    logic                           cfg_accept;
    logic                           c_hs;
    logic                           zero_dim;
    logic [1:0]                     err_set;
    logic [RegDataWidth-1:0]        out_count_inc;
    logic [2*DimWidth-1:0]          dim_prod;

    assign cfg_accept    = csr_cfg_valid_i && cfg_ready_q;
    assign c_hs          = gemm_c_valid_i && gemm_c_ready_i;
    assign zero_dim      = (csr_cfg_i[0] == '0) || (csr_cfg_i[1] == '0)
                        || (csr_cfg_i[2] == '0);
    assign out_count_inc = out_count_q + RegDataWidth'(1);
    assign dim_prod      = {{DimWidth{1'b0}}, pend_cfg_q[2][DimWidth-1:0]}
                         * {{DimWidth{1'b0}}, pend_cfg_q[1][DimWidth-1:0]};

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_cfg_d   = pend_cfg_q;
        expected_d   = expected_q;
        out_count_d  = out_count_q;
        perf_d       = perf_q;
        done_d       = 1'b0;
        err_set      = 2'b00;

        if (cfg_accept) begin
            if (zero_dim) begin
                err_set[0] = 1'b1;
            end else begin
                pend_cfg_d   = csr_cfg_i;
                pend_valid_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (c_hs) err_set[1] = 1'b1;
                if (pend_valid_q) state_d = ISSUE;
            end
            ISSUE: begin
                if (c_hs) err_set[1] = 1'b1;
                if (gemm_ctrl_ready_i) begin
                    pend_valid_d = 1'b0;
                    expected_d   = RegDataWidth'(dim_prod);
                    out_count_d  = '0;
                    perf_d       = '0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (perf_q != '1) perf_d = perf_q + RegDataWidth'(1);
                if (c_hs) begin
                    out_count_d = out_count_inc;
                    if (out_count_inc == expected_q) begin
                        done_d  = 1'b1;
                        state_d = pend_valid_q ? ISSUE : IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new error in the clearing cycle must survive the clear
        err_d       = (err_clr_i ? 2'b00 : err_q) | err_set;
        cfg_ready_d = !pend_valid_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_cfg_q   <= '0;
            expected_q   <= '0;
            out_count_q  <= '0;
            perf_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 2'b00;
            cfg_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_cfg_q   <= pend_cfg_d;
            expected_q   <= expected_d;
            out_count_q  <= out_count_d;
            perf_q       <= perf_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cfg_ready_q  <= cfg_ready_d;
        end
    end

    assign csr_cfg_ready_o   = cfg_ready_q;
    assign gemm_ctrl_valid_o = (state_q == ISSUE);
    assign gemm_k_o          = pend_cfg_q[0];
    assign gemm_n_o          = pend_cfg_q[1];
    assign gemm_m_o          = pend_cfg_q[2];
    assign gemm_sub_o        = pend_cfg_q[3];
    assign busy_o            = (state_q != IDLE) || pend_valid_q || gemm_busy_i;
    assign done_o            = done_q;
    assign perf_cycles_o     = perf_q;
    assign out_count_o       = out_count_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_gemm_launch_ctrl.sv
// Directed bench for gemm_launch_ctrl: a cycle table for a single job,
// then hand-written sequences for queuing, errors, backpressure and reset.
module tb_gemm_launch_ctrl;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [3:0][31:0] csr_cfg_i;
    logic             csr_cfg_valid_i;
    logic             csr_cfg_ready_o;
    logic             err_clr_i;
    logic             gemm_ctrl_valid_o;
    logic             gemm_ctrl_ready_i;
    logic [31:0]      gemm_k_o, gemm_n_o, gemm_m_o, gemm_sub_o;
    logic             gemm_c_valid_i;
    logic             gemm_c_ready_i;
    logic             gemm_busy_i;
    logic             busy_o;
    logic             done_o;
    logic [31:0]      perf_cycles_o;
    logic [31:0]      out_count_o;
    logic [1:0]       err_o;

    int checks = 0;
    int errors = 0;

    gemm_launch_ctrl #(
        .RegDataWidth(32),
        .DimWidth    (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .csr_cfg_i        (csr_cfg_i),
        .csr_cfg_valid_i  (csr_cfg_valid_i),
        .csr_cfg_ready_o  (csr_cfg_ready_o),
        .err_clr_i        (err_clr_i),
        .gemm_ctrl_valid_o(gemm_ctrl_valid_o),
        .gemm_ctrl_ready_i(gemm_ctrl_ready_i),
        .gemm_k_o         (gemm_k_o),
        .gemm_n_o         (gemm_n_o),
        .gemm_m_o         (gemm_m_o),
        .gemm_sub_o       (gemm_sub_o),
        .gemm_c_valid_i   (gemm_c_valid_i),
        .gemm_c_ready_i   (gemm_c_ready_i),
        .gemm_busy_i      (gemm_busy_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .perf_cycles_o    (perf_cycles_o),
        .out_count_o      (out_count_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cfg_v;
        logic        ctrl_r;
        logic        c_hs;
        logic        e_ctrl_v;
        logic        e_cfg_r;
        logic        e_done;
        logic        e_busy;
        logic [31:0] e_count;
        logic [31:0] e_perf;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] k, input logic [31:0] n,
                           input logic [31:0] m, input logic [31:0] s);
        csr_cfg_i[0] = k;
        csr_cfg_i[1] = n;
        csr_cfg_i[2] = m;
        csr_cfg_i[3] = s;
    endtask

    task automatic c_drive(input logic v, input logic r);
        gemm_c_valid_i = v;
        gemm_c_ready_i = r;
    endtask

    initial begin
        int vhigh;
        int dones;

        // cfg_v ctrl_r c_hs | ctrl_v cfg_r done busy count perf
        vecs[0]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[2]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 1, 0, 0, 1, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 0, 1, 0, 1, 1, 1};
        vecs[5]  = '{0, 0, 1, 0, 1, 0, 1, 2, 2};
        vecs[6]  = '{0, 0, 1, 0, 1, 0, 1, 3, 3};
        vecs[7]  = '{0, 0, 1, 0, 1, 0, 1, 4, 4};
        vecs[8]  = '{0, 0, 1, 0, 1, 0, 1, 5, 5};
        vecs[9]  = '{0, 0, 1, 0, 1, 1, 0, 6, 6};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 6, 6};

        rst_i = 1'b1;
        set_cfg(0, 0, 0, 0);
        csr_cfg_valid_i   = 1'b0;
        err_clr_i         = 1'b0;
        gemm_ctrl_ready_i = 1'b0;
        gemm_busy_i       = 1'b0;
        c_drive(0, 0);
        step();
        step();

        chk("rst ctrl_valid", gemm_ctrl_valid_o, 0);
        chk("rst cfg_ready", csr_cfg_ready_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst done", done_o, 0);
        chk("rst perf", perf_cycles_o, 0);
        chk("rst count", out_count_o, 0);
        chk("rst err", err_o, 0);
        chk("rst k", gemm_k_o, 0);
        rst_i = 1'b0;
        step();
        chk("post-rst cfg_ready", csr_cfg_ready_o, 1);

        // Test 1: single job through the cycle table
        set_cfg(4, 2, 3, 9);
        vhigh = 0;
        dones = 0;
        for (int i = 0; i < 11; i++) begin
            csr_cfg_valid_i   = vecs[i].cfg_v;
            gemm_ctrl_ready_i = vecs[i].ctrl_r;
            c_drive(vecs[i].c_hs, vecs[i].c_hs);
            step();
            if (gemm_ctrl_valid_o) vhigh++;
            if (done_o) dones++;
            chk($sformatf("t1[%0d] ctrl_valid", i), gemm_ctrl_valid_o, vecs[i].e_ctrl_v);
            chk($sformatf("t1[%0d] cfg_ready", i), csr_cfg_ready_o, vecs[i].e_cfg_r);
            chk($sformatf("t1[%0d] done", i), done_o, vecs[i].e_done);
            chk($sformatf("t1[%0d] busy", i), busy_o, vecs[i].e_busy);
            chk($sformatf("t1[%0d] count", i), out_count_o, vecs[i].e_count);
            chk($sformatf("t1[%0d] perf", i), perf_cycles_o, vecs[i].e_perf);
            if (vecs[i].e_ctrl_v) begin
                chk($sformatf("t1[%0d] k", i), gemm_k_o, 4);
                chk($sformatf("t1[%0d] n", i), gemm_n_o, 2);
                chk($sformatf("t1[%0d] m", i), gemm_m_o, 3);
                chk($sformatf("t1[%0d] sub", i), gemm_sub_o, 9);
            end
        end
        chk("t1 valid cycles", vhigh, 2);
        chk("t1 done pulses", dones, 1);

        // Test 2: job B queued while job A runs
        gemm_ctrl_ready_i = 1'b0;
        c_drive(0, 0);
        set_cfg(1, 2, 2, 5);
        csr_cfg_valid_i = 1'b1;
        step();
        csr_cfg_valid_i = 1'b0;
        step();
        chk("t2 A issue", gemm_ctrl_valid_o, 1);
        chk("t2 A n", gemm_n_o, 2);
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        chk("t2 A run cfg_ready", csr_cfg_ready_o, 1);
        chk("t2 A run count", out_count_o, 0);
        set_cfg(2, 1, 1, 7);
        csr_cfg_valid_i = 1'b1;
        c_drive(1, 1);
        step();
        csr_cfg_valid_i = 1'b0;
        chk("t2 B queued cfg_ready", csr_cfg_ready_o, 0);
        chk("t2 count1", out_count_o, 1);
        step();
        step();
        chk("t2 count3", out_count_o, 3);
        chk("t2 no early done", done_o, 0);
        step();
        c_drive(0, 0);
        chk("t2 A done", done_o, 1);
        chk("t2 A count", out_count_o, 4);
        chk("t2 B issue", gemm_ctrl_valid_o, 1);
        chk("t2 B n", gemm_n_o, 1);
        chk("t2 B sub", gemm_sub_o, 7);
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        chk("t2 B run done", done_o, 0);
        chk("t2 B run count", out_count_o, 0);
        c_drive(1, 1);
        step();
        c_drive(0, 0);
        chk("t2 B done", done_o, 1);
        chk("t2 B count", out_count_o, 1);
        chk("t2 B idle valid", gemm_ctrl_valid_o, 0);
        step();
        chk("t2 done clears", done_o, 0);
        chk("t2 busy low", busy_o, 0);

        // Test 3: zero dimension rejected
        set_cfg(1, 1, 0, 0);
        chk("t3 ready before", csr_cfg_ready_o, 1);
        csr_cfg_valid_i = 1'b1;
        step();
        csr_cfg_valid_i = 1'b0;
        chk("t3 err", err_o, 2'b01);
        chk("t3 busy", busy_o, 0);
        step();
        chk("t3 no issue", gemm_ctrl_valid_o, 0);
        chk("t3 still idle", busy_o, 0);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        chk("t3 err clr", err_o, 0);

        // Test 4: stray output handshake in IDLE
        c_drive(1, 1);
        step();
        chk("t4 err", err_o, 2'b10);
        chk("t4 count held", out_count_o, 1);
        err_clr_i = 1'b1;
        step();
        c_drive(0, 0);
        chk("t4 set beats clr", err_o, 2'b10);
        chk("t4 count held2", out_count_o, 1);
        step();
        err_clr_i = 1'b0;
        chk("t4 err cleared", err_o, 0);

        gemm_busy_i = 1'b1;
        #1;
        chk("core busy", busy_o, 1);
        gemm_busy_i = 1'b0;
        #1;
        chk("core idle", busy_o, 0);

        // Test 5: output backpressure
        set_cfg(3, 2, 2, 0);
        csr_cfg_valid_i = 1'b1;
        step();
        csr_cfg_valid_i = 1'b0;
        step();
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        chk("t5 perf cleared", perf_cycles_o, 0);
        for (int i = 0; i < 8; i++) begin
            c_drive(1, (i % 2) == 1);
            step();
            if (i == 6) begin
                chk("t5 count3", out_count_o, 3);
                chk("t5 no done", done_o, 0);
            end
        end
        c_drive(0, 0);
        chk("t5 count", out_count_o, 4);
        chk("t5 done", done_o, 1);
        chk("t5 perf", perf_cycles_o, 8);
        step();
        chk("t5 perf held", perf_cycles_o, 8);
        chk("t5 count held", out_count_o, 4);
        chk("t5 done off", done_o, 0);

        // Test 6: reset mid-run with a queued job
        set_cfg(1, 2, 2, 3);
        csr_cfg_valid_i = 1'b1;
        step();
        csr_cfg_valid_i = 1'b0;
        step();
        gemm_ctrl_ready_i = 1'b1;
        step();
        gemm_ctrl_ready_i = 1'b0;
        set_cfg(1, 1, 1, 1);
        csr_cfg_valid_i = 1'b1;
        c_drive(1, 1);
        step();
        csr_cfg_valid_i = 1'b0;
        step();
        c_drive(0, 0);
        chk("t6 count2", out_count_o, 2);
        chk("t6 pending", csr_cfg_ready_o, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("t6 ctrl_valid", gemm_ctrl_valid_o, 0);
        chk("t6 cfg_ready", csr_cfg_ready_o, 0);
        chk("t6 busy", busy_o, 0);
        chk("t6 done", done_o, 0);
        chk("t6 count", out_count_o, 0);
        chk("t6 perf", perf_cycles_o, 0);
        chk("t6 err", err_o, 0);
        chk("t6 k", gemm_k_o, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t6[%0d] no issue", i), gemm_ctrl_valid_o, 0);
            chk($sformatf("t6[%0d] no done", i), done_o, 0);
            chk($sformatf("t6[%0d] idle", i), busy_o, 0);
        end
        chk("t6 ready back", csr_cfg_ready_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
